// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: payload width, bubble constant and IF/ID payload layout.
package pipe_pkg;

  localparam int unsigned PIPE_PAYLOAD_W = 64;
  localparam logic [PIPE_PAYLOAD_W-1:0] PIPE_BUBBLE = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pipe_if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with 2-entry skid buffer, flush and global run enable.
// Optional saturating stall/flush counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     WIDTH       = PIPE_PAYLOAD_W,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = WIDTH'(PIPE_BUBBLE),
  parameter int unsigned     PERF_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o,
  output logic [PERF_W-1:0] perf_flush_cnt_o
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;
  logic             acc;
  logic             pop;

  assign in_ready_o  = start_i & ~skid_v & ~rst_i;
  assign out_valid_o = start_i & main_v;
  assign out_data_o  = main_d;
  assign acc         = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Skid absorbs the one extra beat accepted while main is stalled, so in_ready never depends on out_ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= FLUSH_VALUE;
      skid_d <= FLUSH_VALUE;
    end else if (start_i) begin
      if (flush_i) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        main_d <= FLUSH_VALUE;
      end else if (!main_v || pop) begin
        if (skid_v) begin
          main_v <= 1'b1;
          main_d <= skid_d;
          skid_v <= 1'b0;
        end else begin
          main_v <= acc;
          if (acc) begin
            main_d <= in_data_i;
          end
        end
      end else if (acc) begin
        skid_v <= 1'b1;
        skid_d <= in_data_i;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_v & start_i & ~out_ready_i;
  assign flush_inc = start_i & flush_i;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (perf_stall_cnt_o)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (perf_flush_cnt_o)
  );
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard checking every downstream pop.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [PW-1:0] stall_cnt;
  logic [PW-1:0] flush_cnt;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [W-1:0] exp_q[$];

  pipe_stage_reg #(.WIDTH(W), .FLUSH_VALUE('0), .PERF_W(PW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_data_i        (in_data),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_data_o       (out_data),
    .perf_stall_cnt_o (stall_cnt),
    .perf_flush_cnt_o (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic [31:0] instr);
    pipe_if_id_t p;
    p.pc = pc;
    p.instr = instr;
    return W'(p);
  endfunction

  // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge where they complete.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (start) begin
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected act=%h exp=none t=%0t", out_data, $time);
        end else begin
          chk("sb_data", out_data, exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  logic [W-1:0] a, b, c, d, e;
  int p0;

  initial begin
    a = mk(32'h0000_0100, 32'hAAAA_0001);
    b = mk(32'h0000_0104, 32'hBBBB_0002);
    c = mk(32'h0000_0108, 32'hCCCC_0003);
    d = mk(32'h0000_010C, 32'hDDDD_0004);
    e = mk(32'h0000_0110, 32'hEEEE_0005);

    // 1: reset then streaming
    step();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", W'(in_ready), W'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    p0 = pops;
    drive(1'b1, a); step();
    chk("s1_a_valid", W'(out_valid), W'(1));
    chk("s1_a_data", out_data, a);
    chk("s1_ready_a", W'(in_ready), W'(1));
    drive(1'b1, b); step();
    chk("s1_b_data", out_data, b);
    chk("s1_ready_b", W'(in_ready), W'(1));
    drive(1'b1, c); step();
    chk("s1_c_data", out_data, c);
    drive(1'b0, '0); step();
    chk("s1_drained", W'(out_valid), W'(0));
    chk("s1_data_hold", out_data, c);
    chk("s1_pops", W'(pops - p0), W'(3));

    // 2: back-pressure into skid, then ordered drain
    out_ready = 1'b0;
    p0 = pops;
    drive(1'b1, a); step();
    chk("s2_main_a", out_data, a);
    chk("s2_ready_main", W'(in_ready), W'(1));
    drive(1'b1, b); step();
    chk("s2_skid_full_ready", W'(in_ready), W'(0));
    chk("s2_still_a", out_data, a);
    drive(1'b1, c); step();
    chk("s2_c_blocked", W'(in_ready), W'(0));
    chk("s2_still_a2", out_data, a);
    out_ready = 1'b1; step();
    chk("s2_b_data", out_data, b);
    chk("s2_ready_back", W'(in_ready), W'(1));
    step();
    chk("s2_c_data", out_data, c);
    drive(1'b0, '0); step();
    chk("s2_drained", W'(out_valid), W'(0));
    chk("s2_pops", W'(pops - p0), W'(3));

    // 3: flush with both entries full, and flush discarding a same-cycle accept
    out_ready = 1'b0;
    drive(1'b1, a); step();
    drive(1'b1, b); step();
    flush = 1'b1; drive(1'b1, d); step();
    chk("s3_flush_valid", W'(out_valid), W'(0));
    chk("s3_flush_data", out_data, '0);
    chk("s3_flush_ready", W'(in_ready), W'(1));
    flush = 1'b0; drive(1'b1, a); step();
    flush = 1'b1; drive(1'b1, d); step();
    chk("s3_acc_discard_valid", W'(out_valid), W'(0));
    flush = 1'b0; drive(1'b0, '0); out_ready = 1'b1; step();
    chk("s3_d_never", W'(out_valid), W'(0));
    chk("s3_data_bubble", out_data, '0);

    // 4: frozen stage ignores everything, including flush
    out_ready = 1'b0;
    drive(1'b1, a); step();
    start = 1'b0; flush = 1'b1; out_ready = 1'b1; drive(1'b1, e);
    #1;
    chk("s4_frozen_ready", W'(in_ready), W'(0));
    chk("s4_frozen_valid", W'(out_valid), W'(0));
    step(); step();
    chk("s4_frozen_data", out_data, a);
    chk("s4_frozen_valid2", W'(out_valid), W'(0));
    p0 = pops;
    start = 1'b1; flush = 1'b0; drive(1'b0, '0);
    #1;
    chk("s4_resume_valid", W'(out_valid), W'(1));
    step();
    chk("s4_a_popped", W'(pops - p0), W'(1));
    chk("s4_empty", W'(out_valid), W'(0));

    // 5: reset mid-stream with both entries full
    out_ready = 1'b0;
    drive(1'b1, a); step();
    drive(1'b1, b); step();
    rst = 1'b1; drive(1'b0, '0); step();
    chk("s5_rst_valid", W'(out_valid), W'(0));
    chk("s5_rst_ready", W'(in_ready), W'(0));
    chk("s5_rst_data", out_data, '0);
    rst = 1'b0;
    #1;
    chk("s5_ready_after", W'(in_ready), W'(1));

    // 6: performance counters
    chk("s6_stall_clr", W'(stall_cnt), W'(0));
    chk("s6_flush_clr", W'(flush_cnt), W'(0));
    drive(1'b1, a); step();
    drive(1'b0, '0);
    for (int i = 0; i < 20; i++) step();
`ifdef PIPE_STAGE_PERF_EN
    chk("s6_stall_sat", W'(stall_cnt), W'(15));
`else
    chk("s6_stall_off", W'(stall_cnt), W'(0));
`endif
    flush = 1'b1; step();
    flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    chk("s6_flush_1", W'(flush_cnt), W'(1));
`else
    chk("s6_flush_off", W'(flush_cnt), W'(0));
`endif
    flush = 1'b1; step();
    flush = 1'b0; step();
`ifdef PIPE_STAGE_PERF_EN
    chk("s6_flush_2", W'(flush_cnt), W'(2));
    chk("s6_stall_hold", W'(stall_cnt), W'(15));
`else
    chk("s6_flush_off2", W'(flush_cnt), W'(0));
`endif
    chk("s6_after_flush", W'(out_valid), W'(0));

    step();
    chk("sb_leftover", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
